// File: rtl/ula_n_bits_seq.sv
// ula_n_bits_seq: multi-cycle WIDTH-bit ALU built around one 74181-style
// 4-bit slice that is reused over NSLICE cycles, least-significant nibble
// first, with the carry held in a register between cycles. Ready/valid on
// both sides so it can sit between pipelined datapath stages.
//
// Optional feature: define ULA_SEQ_ZERO_FLAG_EN to add the 'zero' output
// (result == 0, valid together with out_valid).
module ula_n_bits_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             overflow,
  output logic             p,
  output logic             g
`ifdef ULA_SEQ_ZERO_FLAG_EN
  ,
  output logic             zero
`endif
);

  localparam int NSLICE = WIDTH / 4;
  localparam int KW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NSLICE - 1);

  if (((WIDTH % 4) != 0) || (WIDTH < 8)) begin : g_bad_width
    $fatal(1, "ula_n_bits_seq: WIDTH must be a multiple of 4 and at least 8");
  end

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d;
  logic [3:0]       s_q, s_d;
  logic             m_q, m_d;
  logic             carry_q, carry_d;
  logic             aeqb_q, aeqb_d;
  logic             p_q, p_d;
  logic             g_q, g_d;
  logic             ovf_q, ovf_d;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  logic             zero_q, zero_d;
`endif

  // ---------------------------------------------------------------------
  // The shared 4-bit slice. Each bit is reduced to a pair (x, y) such that
  // arithmetic mode computes x + y + carry; y implies x, so y is the bit
  // generate and x the bit propagate. Logic mode is the carry-free ~(x ^ y).
  // ---------------------------------------------------------------------
  logic [KW+1:0] base;
  logic [3:0]    sl_a, sl_b, sl_x, sl_y, sl_f;
  logic [3:1]    sl_c;
  logic          sl_p, sl_g, sl_c_out, sl_aeqb;

  assign base = {k_q, 2'b00};
  assign sl_a = a_q[base +: 4];
  assign sl_b = b_q[base +: 4];

  assign sl_x = sl_a | (sl_b & {4{s_q[0]}}) | (~sl_b & {4{s_q[1]}});
  assign sl_y = (sl_a & sl_b & {4{s_q[3]}}) | (sl_a & ~sl_b & {4{s_q[2]}});

  assign sl_c[1] = sl_y[0] | (sl_x[0] & carry_q);
  assign sl_c[2] = sl_y[1] | (sl_x[1] & sl_y[0]) | (sl_x[1] & sl_x[0] & carry_q);
  assign sl_c[3] = sl_y[2] | (sl_x[2] & sl_y[1]) | (sl_x[2] & sl_x[1] & sl_y[0])
                 | (sl_x[2] & sl_x[1] & sl_x[0] & carry_q);

  assign sl_p     = &sl_x;
  assign sl_g     = sl_y[3] | (sl_x[3] & sl_y[2]) | (sl_x[3] & sl_x[2] & sl_y[1])
                  | (sl_x[3] & sl_x[2] & sl_x[1] & sl_y[0]);
  assign sl_c_out = sl_g | (sl_p & carry_q);
  assign sl_f     = sl_x ^ sl_y ^ (m_q ? 4'hF : {sl_c, carry_q});
  // Equality of the operand nibbles, independent of the selected function.
  assign sl_aeqb  = (sl_a == sl_b);

  // Next-state, operand capture and per-slice accumulation.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; without this the tool would infer latches.
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    m_d     = m_q;
    f_d     = f_q;
    carry_d = carry_q;
    aeqb_d  = aeqb_q;
    p_d     = p_q;
    g_d     = g_q;
    ovf_d   = ovf_q;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    zero_d  = zero_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          s_d     = s;
          m_d     = m;
          carry_d = c_in;
          k_d     = '0;
          aeqb_d  = 1'b1;
          p_d     = 1'b1;
          g_d     = 1'b0;
          ovf_d   = 1'b0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
          zero_d  = 1'b1;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        f_d[base +: 4] = sl_f;
        carry_d = sl_c_out;
        aeqb_d  = aeqb_q & sl_aeqb;
        p_d     = p_q & sl_p;
        g_d     = sl_g | (sl_p & g_q);
`ifdef ULA_SEQ_ZERO_FLAG_EN
        zero_d  = zero_q & (sl_f == 4'h0);
`endif
        k_d     = k_q + 1'b1;
        if (k_q == K_LAST) begin
          k_d     = '0;
          state_d = S_DONE;
          // sl_f[3] is the result msb being written on this edge.
          if (!m_q && (s_q == 4'b1001))
            ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sl_f[3] != a_q[WIDTH-1]);
          else if (!m_q && (s_q == 4'b0110))
            ovf_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (sl_f[3] == b_q[WIDTH-1]);
          else
            ovf_d = 1'b0;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      m_q     <= 1'b0;
      f_q     <= '0;
      carry_q <= 1'b0;
      aeqb_q  <= 1'b0;
      p_q     <= 1'b0;
      g_q     <= 1'b0;
      ovf_q   <= 1'b0;
`ifdef ULA_SEQ_ZERO_FLAG_EN
      zero_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      m_q     <= m_d;
      f_q     <= f_d;
      carry_q <= carry_d;
      aeqb_q  <= aeqb_d;
      p_q     <= p_d;
      g_q     <= g_d;
      ovf_q   <= ovf_d;
`ifdef ULA_SEQ_ZERO_FLAG_EN
      zero_q  <= zero_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign f         = f_q;
  assign c_out     = carry_q;
  assign a_eq_b    = aeqb_q;
  assign overflow  = ovf_q;
  assign p         = p_q;
  assign g         = g_q;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_ula_n_bits_seq.sv
// tb_ula_n_bits_seq: randomized scoreboard bench for ula_n_bits_seq.
// The driver pushes the word-level expected response on every accepted
// request; an independent monitor compares whenever out_valid is high.
module tb_ula_n_bits_seq;

  localparam int W  = 16;
  localparam int NS = W / 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, f;
  logic [3:0]   s;
  logic         m, c_in, c_out, a_eq_b, overflow, p, g;
`ifdef ULA_SEQ_ZERO_FLAG_EN
  logic         zero;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  bit hold     = 1'b0;
  bit first_seen = 1'b0;

  // v packs {in_ready, c_out, a_eq_b, overflow, p, g, zero, f}
  typedef struct {
    logic [W+6:0] v;
    int           acc;
  } exp_t;
  exp_t exp_q[$];

  ula_n_bits_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .s(s), .m(m), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .f(f), .c_out(c_out), .a_eq_b(a_eq_b), .overflow(overflow),
    .p(p), .g(g)
`ifdef ULA_SEQ_ZERO_FLAG_EN
    , .zero(zero)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
  endtask

  function automatic logic [W+6:0] pack_act();
    logic z;
`ifdef ULA_SEQ_ZERO_FLAG_EN
    z = zero;
`else
    z = 1'b0;
`endif
    return {in_ready, c_out, a_eq_b, overflow, p, g, z, f};
  endfunction

  function automatic logic [W:0] ext(input logic [W-1:0] v);
    return {1'b0, v};
  endfunction

  // Reference: 74181 function table evaluated on whole words.
  function automatic logic [W+6:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                         input logic [3:0] xs, input logic xm, input logic xc);
    logic [W:0]   r0, r;
    logic [W-1:0] ones, lf, res, px;
    logic         ovf, z;
    ones = '1;
    case (xs)
      4'd0:  r0 = ext(xa);
      4'd1:  r0 = ext(xa | xb);
      4'd2:  r0 = ext(xa | ~xb);
      4'd3:  r0 = ext(ones);
      4'd4:  r0 = ext(xa) + ext(xa & ~xb);
      4'd5:  r0 = ext(xa | xb) + ext(xa & ~xb);
      4'd6:  r0 = ext(xa) + ext(~xb);
      4'd7:  r0 = ext(xa & ~xb) + ext(ones);
      4'd8:  r0 = ext(xa) + ext(xa & xb);
      4'd9:  r0 = ext(xa) + ext(xb);
      4'd10: r0 = ext(xa | ~xb) + ext(xa & xb);
      4'd11: r0 = ext(xa & xb) + ext(ones);
      4'd12: r0 = ext(xa) + ext(xa);
      4'd13: r0 = ext(xa | xb) + ext(xa);
      4'd14: r0 = ext(xa | ~xb) + ext(xa);
      default: r0 = ext(xa) + ext(ones);
    endcase
    r = r0 + (W+1)'(xc);
    case (xs)
      4'd0:  lf = ~xa;
      4'd1:  lf = ~(xa | xb);
      4'd2:  lf = ~xa & xb;
      4'd3:  lf = '0;
      4'd4:  lf = ~(xa & xb);
      4'd5:  lf = ~xb;
      4'd6:  lf = xa ^ xb;
      4'd7:  lf = xa & ~xb;
      4'd8:  lf = ~xa | xb;
      4'd9:  lf = ~(xa ^ xb);
      4'd10: lf = xb;
      4'd11: lf = xa & xb;
      4'd12: lf = ones;
      4'd13: lf = xa | ~xb;
      4'd14: lf = xa | xb;
      default: lf = xa;
    endcase
    res = xm ? lf : r[W-1:0];
    px  = xa | (xs[0] ? xb : '0) | (xs[1] ? ~xb : '0);
    ovf = 1'b0;
    if (!xm && xs == 4'b1001) ovf = (xa[W-1] == xb[W-1]) && (res[W-1] != xa[W-1]);
    if (!xm && xs == 4'b0110) ovf = (xa[W-1] != xb[W-1]) && (res[W-1] == xb[W-1]);
`ifdef ULA_SEQ_ZERO_FLAG_EN
    z = (res == '0);
`else
    z = 1'b0;
`endif
    return {1'b0, r[W], (xa == xb), ovf, (&px), r0[W], z, res};
  endfunction

  // Monitor: compares the head of the scoreboard while a result is presented.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_result: got out_valid=1 with f=%h, required no pending result", f);
      end else begin
        if (!first_seen) begin
          check("latency", 64'(cyc - exp_q[0].acc), 64'(NS));
          first_seen = 1'b1;
        end
        check("result", 64'(pack_act()), 64'(exp_q[0].v));
        if (out_ready) begin
          void'(exp_q.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  // Consumer: random back-pressure, forced low while hold is set.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  task automatic issue(input logic [W-1:0] xa, input logic [W-1:0] xb,
                       input logic [3:0] xs, input logic xm, input logic xc);
    exp_t e;
    int   n;
    @(negedge clk);
    a = xa; b = xb; s = xs; m = xm; c_in = xc;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL accept_timeout: in_ready=0 after %0d cycles, required 1", n);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    e.v   = model(xa, xb, xs, xm, xc);
    e.acc = cyc;
    exp_q.push_back(e);
    // Scramble inputs after acceptance; they must not influence the result.
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); s = 4'($urandom);
    m = 1'($urandom); c_in = 1'($urandom);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
      first_seen = 1'b0;
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return {1'b1, {(W-1){1'b0}}};
      3: return {1'b0, {(W-1){1'b1}}};
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W+6:0] rst_v;
    int n;
    rst_v = {1'b1, 6'b0, {W{1'b0}}};
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; c_in = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs", 64'(pack_act()), 64'(rst_v));
    check("reset_out_valid", 64'(out_valid), 64'(0));
    rst = 1'b0;

    // Directed cases
    issue(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    issue(16'hFFFF, 16'h0000, 4'b1001, 1'b0, 1'b1);
    issue(16'h8000, 16'h0001, 4'b0110, 1'b0, 1'b1);
    issue(16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b1);
    issue(16'hAAAA, 16'h5555, 4'b0110, 1'b1, 1'b0);

    // Every {m,s} with both carry-in values
    for (int ms = 0; ms < 32; ms++)
      for (int ci = 0; ci < 2; ci++)
        issue(pick(), pick(), 4'(ms), 1'(ms >> 4), 1'(ci));

    // Random operations with random back-pressure
    for (int i = 0; i < 120; i++)
      issue(pick(), pick(), 4'($urandom), 1'($urandom), 1'($urandom));
    drain();

    // Result held stable under back-pressure, in_ready low in DONE
    hold = 1'b1;
    issue(W'($urandom), W'($urandom), 4'b1001, 1'b0, 1'($urandom));
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("hold_out_valid", 64'(out_valid), 64'(1));
    repeat (10) @(negedge clk);
    hold = 1'b0;
    drain();

    // in_valid during RUN must not start a second operation
    issue(W'($urandom), W'($urandom), 4'b0110, 1'b0, 1'b1);
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    drain();
    repeat (10) @(negedge clk);

    // Asynchronous reset after the second slice edge aborts the operation
    hold = 1'b1;
    issue(W'($urandom), W'($urandom), 4'b1001, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort_outputs", 64'(pack_act()), 64'(rst_v));
    check("abort_out_valid", 64'(out_valid), 64'(0));
    exp_q.delete();
    first_seen = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    hold = 1'b0;
    issue(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b0);
    issue(W'($urandom), W'($urandom), 4'($urandom), 1'($urandom), 1'($urandom));
    drain();
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
